// File: rtl/rect_frame_sequencer.sv
// Program/pixel bus master for a chain of rect_renderer stages.
// Ports: cmd_* in (valid/ready), frame_start/bg_color/pix_ready in; program_out, x/y/data_out, pix_valid, frame_busy/done, bad_cmd out.
module rect_frame_sequencer #(
  parameter int SCREEN_W = 1080,
  parameter int SCREEN_H = 2160,
  parameter int NUM_REGS = 5
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [10:0] cmd_shape,
  input  logic [2:0]  cmd_reg,
  input  logic [31:0] cmd_data,
  input  logic        frame_start,
  input  logic [31:0] bg_color,
  input  logic        pix_ready,
  output logic        program_out,
  output logic [10:0] x_out,
  output logic [11:0] y_out,
  output logic [31:0] data_out,
  output logic        pix_valid,
  output logic        frame_busy,
  output logic        frame_done,
  output logic        bad_cmd
);

  typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

  localparam logic [10:0] X_LAST  = 11'(SCREEN_W - 1);
  localparam logic [11:0] Y_LAST  = 12'(SCREEN_H - 1);
  localparam logic [3:0]  REG_LIM = 4'(NUM_REGS);

  state_t state;
  logic   start_pend;
  logic   x_end;
  logic   y_end;

  assign cmd_ready = rst_n & (state == IDLE);
  assign x_end     = (x_out == X_LAST);
  assign y_end     = (y_out == Y_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      start_pend  <= 1'b0;
      program_out <= 1'b0;
      x_out       <= '0;
      y_out       <= '0;
      data_out    <= '0;
      pix_valid   <= 1'b0;
      frame_busy  <= 1'b0;
      frame_done  <= 1'b0;
      bad_cmd     <= 1'b0;
    end else begin
      program_out <= 1'b0;
      bad_cmd     <= 1'b0;
      frame_done  <= 1'b0;
      unique case (state)
        IDLE: begin
          pix_valid  <= 1'b0;
          frame_busy <= 1'b0;
          if (cmd_valid) begin
            // A command wins; remember the frame request for later.
            if (frame_start)
              start_pend <= 1'b1;
            if ({1'b0, cmd_reg} >= REG_LIM) begin
              bad_cmd <= 1'b1;
            end else begin
              program_out <= 1'b1;
              x_out       <= cmd_shape;
              y_out       <= {9'd0, cmd_reg};
              data_out    <= cmd_data;
            end
          end else if (frame_start | start_pend) begin
            start_pend <= 1'b0;
            state      <= SCAN;
            x_out      <= '0;
            y_out      <= '0;
            data_out   <= bg_color;
            pix_valid  <= 1'b1;
            frame_busy <= 1'b1;
          end
        end
        SCAN: begin
          if (pix_ready) begin
            if (x_end && y_end) begin
              state      <= DONE;
              pix_valid  <= 1'b0;
              frame_done <= 1'b1;
            end else if (x_end) begin
              x_out    <= '0;
              y_out    <= y_out + 12'd1;
              data_out <= bg_color;
            end else begin
              x_out    <= x_out + 11'd1;
              data_out <= bg_color;
            end
          end
        end
        DONE: begin
          // frame_busy covers the DONE cycle and falls with IDLE.
          state      <= IDLE;
          frame_busy <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/rect_frame_sequencer.md
Name: rect_frame_sequencer

Overview:
- Controller that sits in front of a chain of rect_renderer stages and is the only source of their program/pixel bus.
- Accepts shape-register write commands over a valid/ready port and issues them as program cycles (program_out=1, x=shape index, y=register index, data=value).
- On a frame request it raster-scans the full screen, driving pixel coordinates with the background colour on data_out. Downstream can apply back-pressure.
- Shape registers change only between frames, never mid-scan.

Parameters:
- SCREEN_W, 1080, pixels per row; x range 0..SCREEN_W-1.
- SCREEN_H, 2160, rows per frame; y range 0..SCREEN_H-1.
- NUM_REGS, 5, valid register indices 0..NUM_REGS-1 (0 x_pos, 1 y_pos, 2 width, 3 height, 4 colour).

Ports:
- clk  in  1  system clock, all logic on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  command accepted when cmd_valid&cmd_ready.
- cmd_shape  in  11  target shape/stage index.
- cmd_reg  in  3  register index.
- cmd_data  in  32  register value.
- frame_start  in  1  single-cycle request to render one frame.
- bg_color  in  32  background colour, sampled per pixel.
- pix_ready  in  1  downstream can take the current pixel.
- program_out  out  1  program cycle to renderer chain.
- x_out  out  11  shape index (program) / pixel x (scan).
- y_out  out  12  register index (program) / pixel y (scan).
- data_out  out  32  register value (program) / bg_color (scan).
- pix_valid  out  1  x_out/y_out/data_out carry a scan pixel.
- frame_busy  out  1  high from the first SCAN cycle through the DONE cycle.
- frame_done  out  1  one-cycle pulse after the last pixel is accepted.
- bad_cmd  out  1  one-cycle pulse when a command with cmd_reg>=NUM_REGS is accepted.

Behaviour:
- Reset (rst_n low, async): state=IDLE. All registered outputs are 0: program_out, x_out, y_out, data_out, pix_valid, frame_busy, frame_done, bad_cmd, start_pend. The reset applies immediately even mid-scan; no partial frame_done is produced.
- cmd_ready = (state==IDLE), combinational. It is 0 while rst_n is low.
- States: IDLE, SCAN, DONE.
- IDLE, command accepted:
  - Next cycle program_out=1, x_out=cmd_shape, y_out=zero-extended cmd_reg, data_out=cmd_data, for exactly one cycle.
  - Back-to-back commands give back-to-back program cycles (1-cycle latency, full throughput).
  - If cmd_reg>=NUM_REGS: program_out stays 0, bad_cmd pulses, and the command is otherwise dropped.
- IDLE priority: a command has priority over a frame start.
  - frame_start with cmd_valid=1 sets start_pend.
  - The scan begins on the first IDLE cycle with cmd_valid=0 and (frame_start|start_pend). start_pend clears at that point.
- Entering SCAN: x_out=0, y_out=0, data_out=bg_color, pix_valid=1, program_out=0, frame_busy=1.
- SCAN advance: on each cycle with pix_valid&pix_ready, step to the next pixel, row-major with x fastest.
  - x wraps from SCREEN_W-1 to 0 and y increments at the same time.
  - data_out reloads bg_color on every advance.
  - With pix_ready=0, all outputs hold.
- Last pixel: when (SCREEN_W-1, SCREEN_H-1) is accepted, go to DONE.
  - In DONE: pix_valid=0 and frame_done=1 for one cycle.
  - Return to IDLE; frame_busy drops on the IDLE cycle.
- Frame cost is SCREEN_W*SCREEN_H accepted pixels plus 1 DONE cycle.
- frame_start outside IDLE is ignored and does not set start_pend. cmd_valid outside IDLE stalls (cmd_ready=0).
- Counter widths: x 11 bits, y 12 bits. The defaults fit these widths with no overflow; parameter values above 2048 or 4096 are illegal.

Test Plan:
- Program sequence: reset, then commands (shape 0, reg 2, 1080), (0, 3, 2160), (0, 4, 0xFF000000) back-to-back. Required: three consecutive program_out=1 cycles carrying x_out=0, y_out=2/3/4 and the matching data; cmd_ready=1 throughout.
- Bad register: command with cmd_reg=6, data 0x1234. Required: bad_cmd pulses once, program_out stays 0, the next valid command is still issued normally.
- Full scan (SCREEN_W=8, SCREEN_H=4, pix_ready=1, bg_color=0xFF0000FF): frame_start. Required:
  - 32 consecutive pix_valid cycles, (x,y) = (0,0),(1,0)…(7,0),(0,1)…(7,3), data_out=0xFF0000FF on each.
  - frame_done pulses on the 33rd cycle; frame_busy low the cycle after.
- Back-pressure: same scan with pix_ready toggling 1,0,0,1… Required: outputs held while pix_ready=0, no pixel skipped or duplicated, 32 accepted pixels, then one frame_done.
- Arbitration: assert cmd_valid and frame_start in the same IDLE cycle. Required: the command is issued first and the scan starts the next cycle. Then assert cmd_valid during SCAN; required: cmd_ready=0 until frame_done, and the command is issued on the first IDLE cycle.
- Reset mid-scan: drop rst_n at pixel (3,2). Required: all outputs 0 immediately, no frame_done; after release, state is IDLE and cmd_ready=1.
